// File: rtl/dm_pkg.sv
// Shared encodings for MIPS data-memory accesses.
package dm_pkg;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic        we;
    size_e       size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_req_t;

endpackage

// File: rtl/dm_lane_steer.sv
// Byte-lane steering: enables, store replication, load extract/extend,
// and alignment check for one access.
module dm_lane_steer
  import dm_pkg::*;
(
  input  size_e                  size,
  input  logic [1:0]             addr,
  input  logic                   sign,
  input  logic [31:0]            wdata,
  input  logic [31:0]            rdata,
  output logic [NUM_LANES-1:0]   be,
  output logic [31:0]            wdata_rep,
  output logic [31:0]            rdata_ext,
  output logic                   misaligned
);

  logic [NUM_LANES-1:0][VEC_W-1:0] wd_lanes;
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_lanes;

  assign rd_lanes  = rdata;
  assign wdata_rep = wd_lanes;

  // Per-lane enable and store-data source selection.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LN = 2'(i);
    assign be[i] = (size == SZ_WORD) ||
                   (size == SZ_HALF && LN[1] == addr[1]) ||
                   (size == SZ_BYTE && LN == addr);
    assign wd_lanes[i] = (size == SZ_WORD) ? wdata[VEC_W*i +: VEC_W] :
                         (size == SZ_HALF) ? wdata[VEC_W*(i%2) +: VEC_W] :
                                             wdata[VEC_W-1:0];
  end

  // Alignment rules: halves on even bytes, words on 4-byte boundaries.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_HALF: misaligned = addr[0];
      SZ_WORD: misaligned = |addr;
      SZ_ILL:  misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Load extraction from the addressed lane(s), then sign/zero extension.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = rd_lanes[addr];
    h = {rd_lanes[{addr[1], 1'b1}], rd_lanes[{addr[1], 1'b0}]};
    rdata_ext = rdata;
    case (size)
      SZ_BYTE: rdata_ext = {{24{sign & b[7]}}, b};
      SZ_HALF: rdata_ext = {{16{sign & h[15]}}, h};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory sequencer: one access at a time over a req/ack bus,
// with alignment exceptions and a bus-timeout abort.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        timeout_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  dm_req_t          req_q;
  dm_req_t          req_in;
  dm_req_t          req_sel;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] st_rdata;
  logic        st_misal;

  assign req_in = '{we: req_we, size: size_e'(req_size), sign: req_sign,
                    addr: req_addr, wdata: req_wdata};

  // In IDLE the live request is checked for alignment; afterwards the
  // latched copy drives the bus so it stays constant for the whole access.
  assign req_sel = (state == IDLE) ? req_in : req_q;

  dm_lane_steer u_steer (
    .size       (req_sel.size),
    .addr       (req_sel.addr[1:0]),
    .sign       (req_sel.sign),
    .wdata      (req_sel.wdata),
    .rdata      (bus_rdata),
    .be         (st_be),
    .wdata_rep  (st_wdata),
    .rdata_ext  (st_rdata),
    .misaligned (st_misal)
  );

  // rst_n is folded in so the pipeline is released the instant reset hits.
  assign stall     = rst_n & req_valid & (state != RESP);
  assign bus_req   = (state == BUS);
  assign bus_we    = bus_req & req_q.we;
  assign bus_be    = bus_req ? st_be : 4'b0000;
  assign bus_addr  = {req_q.addr[31:2], 2'b00};
  assign bus_wdata = bus_req ? st_wdata : 32'h0;

  // Access FSM, timeout counter and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      req_q       <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      exc_adel    <= 1'b0;
      exc_ades    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q <= req_in;
            cnt   <= '0;
            if (st_misal) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              exc_adel   <= ~req_we;
              exc_ades   <= req_we;
            end else begin
              state <= BUS;
            end
          end
        end
        BUS: begin
          // An ack on the final allowed cycle still completes normally.
          if (bus_ack) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= req_q.we ? 32'h0 : st_rdata;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state       <= RESP;
            resp_valid  <= 1'b1;
            resp_rdata  <= '0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state       <= IDLE;
          resp_valid  <= 1'b0;
          resp_rdata  <= '0;
          exc_adel    <= 1'b0;
          exc_ades    <= 1'b0;
          timeout_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Sequences every MEM-stage load/store onto the data-memory bus using a req/ack handshake.
- Converts an access size and address into byte enables, replicated store data and extracted, extended load data.
- Stalls the pipeline until the access completes, flags misaligned addresses as AdEL/AdES, and aborts a bus that never acknowledges.
- Sits between the MEM pipeline register and the data memory / bridge.

Parameters:
- TIMEOUT, 255: maximum number of BUS-state cycles without bus_ack before the access aborts; must be ≥ 1.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  MEM stage presents an access
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_sign  in  1  load sign-extend (lb/lh); 0 = zero-extend (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  freeze the pipeline upstream of MEM
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result, valid with resp_valid
- exc_adel  out  1  misaligned load, valid with resp_valid
- exc_ades  out  1  misaligned store, valid with resp_valid
- timeout_err  out  1  bus timeout, valid with resp_valid
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_be  out  4  byte enables, bit i = byte lane i
- bus_addr  out  32  word-aligned address, {req_addr[31:2], 2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completion; read data valid in the same cycle
- bus_rdata  in  32  raw read word

Behaviour:
- States: IDLE, BUS, RESP.
- Reset (async, rst_n=0): state=IDLE, counter=0, all request and response registers cleared, every output 0. Reset mid-operation drops bus_req in the same instant and abandons the access; no resp_valid follows.
- IDLE:
  - req_valid=1 latches we, size, sign, addr and wdata.
  - Misaligned cases: size=01 with addr[0]=1; size=10 with addr[1:0]≠0; size=11 at any address.
  - Misaligned → RESP with exc_adel (load) or exc_ades (store) latched. No bus activity.
  - Aligned → BUS, counter=0.
- BUS:
  - bus_req=1; bus_we, bus_be, bus_addr and bus_wdata come from the latched request and stay constant until exit.
  - bus_ack=1 → latch the extended load data (0 for stores) and go to RESP.
  - No ack → counter++. When the counter reaches TIMEOUT-1 without ack: go to RESP with timeout_err, resp_rdata=0.
  - An ack in the same cycle as the timeout wins; timeout_err stays 0.
- RESP: resp_valid=1 for exactly one cycle with the latched flags and data, then IDLE. New requests are not accepted in RESP.
- stall = req_valid & (state≠RESP), combinational.
  - Minimum aligned latency: accept cycle + 1 BUS cycle + RESP, i.e. stall high for 2 cycles.
  - Misaligned access: stall high for 1 cycle.
- bus_ack outside BUS is ignored.
- Once accepted, an access completes even if req_valid drops; resp_valid still pulses.
- Byte enables:
  - Word → 1111.
  - Half → 0011 when addr[1]=0, 1100 when addr[1]=1.
  - Byte → 0001 << addr[1:0].
  - bus_be=0000 whenever bus_req=0.
- Store data: byte → {4{wdata[7:0]}}, half → {2{wdata[15:0]}}, word → wdata.
- Load data:
  - Byte: lane addr[1:0] of bus_rdata.
  - Half: bytes {2·addr[1]+1, 2·addr[1]}.
  - Extend to 32 bits, sign-extended per req_sign; word loads ignore req_sign.
- All outputs are registered except stall and the bus_* group, which decode directly from the state and the latched request.

Decomposition:
- Shared package dm_pkg:
  - Size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State enum {IDLE, BUS, RESP}.
  - Store to packages with the other MIPS access encodings.
- One combinational sub-module, dm_lane_steer:
  - Inputs: size, addr[1:0], sign, wdata, rdata.
  - Outputs: be, replicated wdata, extended rdata, misaligned flag.
- The FSM and timeout counter stay in the top module.

Test Plan:
- sw addr 0x0000_1004, wdata 0xDEADBEEF, ack on the 1st BUS cycle → bus_be=1111, bus_addr=0x1004, bus_wdata=0xDEADBEEF; stall high 2 cycles; resp_valid 1 cycle; no flags.
- sb addr 0x...07, wdata 0x000000A5, ack after 3 wait cycles → bus_be=1000, bus_wdata=0xA5A5A5A5 held steady for 4 BUS cycles.
- lb addr 0x...02, bus_rdata 0x1280_3456, sign=1 → resp_rdata=0xFFFF_FF80; same with sign=0 → 0x0000_0080. lh addr 0x...02 sign=1 → 0x0000_1280.
- lh addr 0x...03 → exc_adel=1 with resp_valid; bus_req never asserted; stall high 1 cycle. sw addr 0x...02 → exc_ades=1.
- TIMEOUT=4, no ack → bus_req high 4 cycles, then resp_valid with timeout_err=1 and resp_rdata=0. Repeat with ack on the 4th cycle → timeout_err=0.
- rst_n pulsed low during BUS → bus_req and stall drop immediately. After release, state=IDLE and no resp_valid pulse; a late bus_ack is ignored.
